axi4lite_reg_slave: RTL and testbench

AXI4-Lite slave endpoint: a bank of NUM_REGS read/write control registers behind a 32/64-bit AXI4-Lite port. It drives the interface that the AXI4-Lite protocol checker observes, so it must never violate handshake-stability rules or return EXOKAY. It also exposes register contents and per-register write pulses to core logic.

---
 rtl/axi4lite_pkg.sv | 17 +
 rtl/axi4lite_reg_file.sv | 79 +++++++
 rtl/axi4lite_reg_slave.sv | 165 ++++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared response encodings and channel states
// for the AXI4-Lite register slave.
package axi4lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic {
    CH_IDLE,
    CH_RESP
  } ch_state_t;

endpackage

// File: rtl/axi4lite_reg_file.sv
// Register storage, byte-strobe merge,
// write pulses and read mux.
module axi4lite_reg_file
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_en,
  input  logic [ADDR_WIDTH-1:0]          i_wr_addr,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]        i_wr_strb,
  output resp_t                          o_wr_resp,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output resp_t                          o_rd_resp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q,
  output logic [NUM_REGS-1:0]            o_wr_pulse
);

  localparam int SW       = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SPAN =
    ADDR_WIDTH'(NUM_REGS * SW);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pulse;

  logic [ADDR_WIDTH-1:0] w_wr_off;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;

  assign w_wr_off = i_wr_addr - BASE_ADDR;
  assign w_rd_off = i_rd_addr - BASE_ADDR;
  assign w_wr_ok  = (w_wr_off < SPAN);
  assign w_rd_ok  = (w_rd_off < SPAN);
  assign w_wr_idx = w_wr_off[ADDR_LSB +: IDX_W];
  assign w_rd_idx = w_rd_off[ADDR_LSB +: IDX_W];

  assign o_wr_resp = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
  assign o_rd_resp = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
  assign o_rd_data = w_rd_ok ? r_regs[w_rd_idx] : '0;
  assign o_wr_pulse = r_pulse;

  // Pulse fires even with all strobes low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (i_wr_en && w_wr_ok) begin
        r_pulse[w_wr_idx] <= 1'b1;
        for (int b = 0; b < SW; b++) begin
          if (i_wr_strb[b]) begin
            r_regs[w_wr_idx][b*8 +: 8] <=
              i_wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign o_reg_q[g*DATA_WIDTH +: DATA_WIDTH] =
      r_regs[g];
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave front end: handshakes and
// response channels around the register file.
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int SW = DATA_WIDTH / 8;

  ch_state_t r_b_state, w_b_next;
  ch_state_t r_r_state, w_r_next;

  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [SW-1:0]         r_w_strb;
  resp_t                 r_bresp;
  resp_t                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [SW-1:0]         w_wr_strb;
  resp_t                 w_wr_resp;
  resp_t                 w_rd_resp;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  // Protection bits carry no meaning here.
  assign w_unused = ^{AWPROT, ARPROT};

  assign BVALID  = (r_b_state == CH_RESP);
  assign RVALID  = (r_r_state == CH_RESP);
  assign BRESP   = r_bresp;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;

  assign AWREADY = !ARESET && !r_aw_held && !BVALID;
  assign WREADY  = !ARESET && !r_w_held && !BVALID;
  assign ARREADY = !ARESET && !RVALID;

  assign w_aw_hs  = AWVALID && AWREADY;
  assign w_w_hs   = WVALID && WREADY;
  assign w_ar_hs  = ARVALID && ARREADY;
  assign w_commit = (r_aw_held || w_aw_hs) &&
                    (r_w_held || w_w_hs);

  assign w_wr_addr = r_aw_held ? r_aw_addr : AWADDR;
  assign w_wr_data = r_w_held ? r_w_data : WDATA;
  assign w_wr_strb = r_w_held ? r_w_strb : WSTRB;

  always_comb begin
    w_b_next = r_b_state;
    unique case (r_b_state)
      CH_IDLE: if (w_commit) w_b_next = CH_RESP;
      CH_RESP: if (BREADY) w_b_next = CH_IDLE;
      default: w_b_next = CH_IDLE;
    endcase
  end

  always_comb begin
    w_r_next = r_r_state;
    unique case (r_r_state)
      CH_IDLE: if (w_ar_hs) w_r_next = CH_RESP;
      CH_RESP: if (RREADY) w_r_next = CH_IDLE;
      default: w_r_next = CH_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_b_state <= CH_IDLE;
      r_r_state <= CH_IDLE;
    end else begin
      r_b_state <= w_b_next;
      r_r_state <= w_r_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= AWADDR;
      end
      if (w_commit) begin
        r_w_held <= 1'b0;
      end else if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= WDATA;
        r_w_strb <= WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_resp;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end

  axi4lite_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_rf (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_wr_en    (w_commit),
    .i_wr_addr  (w_wr_addr),
    .i_wr_data  (w_wr_data),
    .i_wr_strb  (w_wr_strb),
    .o_wr_resp  (w_wr_resp),
    .i_rd_addr  (ARADDR),
    .o_rd_data  (w_rd_data),
    .o_rd_resp  (w_rd_resp),
    .o_reg_q    (reg_q),
    .o_wr_pulse (reg_wr_pulse)
  );

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave with
// response scoreboards and a register model.
module tb_axi4lite_reg_slave;

  logic         ACLK;
  logic         ARESET;
  logic [31:0]  AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [31:0]  ARADDR;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [511:0] reg_q;
  logic [15:0]  reg_wr_pulse;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [16];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  axi4lite_reg_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (16),
    .BASE_ADDR  (32'h0)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .AWADDR       (AWADDR),
    .AWPROT       (AWPROT),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .ARADDR       (ARADDR),
    .ARPROT       (ARPROT),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pack();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = model[i];
    return p;
  endfunction

  task automatic expect_write(input logic [31:0] a,
                              input logic [31:0] d,
                              input logic [3:0] s);
    if (a < 32'd64) begin
      bq.push_back(2'b00);
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic expect_read(input logic [31:0] a);
    if (a < 32'd64) rq.push_back({2'b00, model[a[5:2]]});
    else            rq.push_back({2'b10, 32'h0});
  endtask

  task automatic check_b(input string tag,
                         input logic [15:0] pulse);
    logic [1:0] e;
    chk({tag, "_bvalid"}, BVALID, 1'b1);
    chk({tag, "_bq"}, bq.size() != 0, 1'b1);
    if (bq.size() != 0) begin
      e = bq.pop_front();
      chk({tag, "_bresp"}, BRESP, e);
    end
    chk({tag, "_regq"}, reg_q, pack());
    chk({tag, "_pulse"}, reg_wr_pulse, pulse);
  endtask

  task automatic check_r(input string tag);
    logic [33:0] e;
    chk({tag, "_rvalid"}, RVALID, 1'b1);
    chk({tag, "_rq"}, rq.size() != 0, 1'b1);
    if (rq.size() != 0) begin
      e = rq.pop_front();
      chk({tag, "_rdata"}, RDATA, e[31:0]);
      chk({tag, "_rresp"}, RRESP, e[33:32]);
    end
  endtask

  task automatic b_accept(input string tag);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk({tag, "_bdrop"}, BVALID, 1'b0);
    chk({tag, "_pclr"}, reg_wr_pulse, 16'h0);
    chk({tag, "_rdy"}, {AWREADY, WREADY}, 2'b11);
  endtask

  task automatic r_accept(input string tag);
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    @(negedge ACLK);
    chk({tag, "_rdrop"}, RVALID, 1'b0);
  endtask

  task automatic write_same(input string tag,
                            input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [3:0] s,
                            input logic [15:0] pulse);
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1;
    chk({tag, "_rdy0"}, {AWREADY, WREADY}, 2'b11);
    expect_write(a, d, s);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check_b(tag, pulse);
    b_accept(tag);
  endtask

  task automatic do_read(input string tag,
                         input logic [31:0] a);
    ARADDR = a; ARVALID = 1'b1;
    chk({tag, "_arrdy"}, ARREADY, 1'b1);
    expect_read(a);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    check_r(tag);
    r_accept(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    ARESET = 1'b1;
    AWADDR = '0; AWPROT = 3'b010; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARADDR = '0; ARPROT = 3'b001; ARVALID = 1'b0;
    RREADY = 1'b0;

    repeat (3) @(negedge ACLK);
    chk("rst_rdy", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valid", {BVALID, RVALID}, 2'b00);
    chk("rst_resp", {BRESP, RRESP, RDATA}, 36'h0);
    chk("rst_regq", reg_q, 512'h0);
    chk("rst_pulse", reg_wr_pulse, 16'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_rdy", {AWREADY, WREADY, ARREADY}, 3'b111);

    write_same("t1", 32'h4, 32'hA5A5A5A5, 4'hF, 16'h0002);

    write_same("t2pre", 32'h8, 32'hFFFFFFFF, 4'hF, 16'h0004);
    WDATA = 32'h11223344; WSTRB = 4'h3; WVALID = 1'b1;
    chk("t2_wrdy", WREADY, 1'b1);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t2_wait_b", BVALID, 1'b0);
      chk("t2_wheld", {AWREADY, WREADY}, 2'b10);
    end
    AWADDR = 32'h8; AWVALID = 1'b1;
    expect_write(32'h8, 32'h11223344, 4'h3);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    @(negedge ACLK);
    check_b("t2", 16'h0004);
    chk("t2_reg2", reg_q[95:64], 32'hFFFF3344);
    b_accept("t2");
    do_read("t2rd", 32'h8);

    do_read("t3rd", 32'h40);
    write_same("t3wr", 32'h40, 32'hDEADBEEF, 4'hF, 16'h0);
    do_read("t3rd1", 32'h4);

    AWADDR = 32'h14; WDATA = 32'hCAFE0005; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    expect_write(32'h14, 32'hCAFE0005, 4'hF);
    @(posedge ACLK); #1;
    AWADDR = 32'h18; WDATA = 32'h66666666; WSTRB = 4'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t4_bvalid", BVALID, 1'b1);
      chk("t4_bresp", BRESP, 2'b00);
      chk("t4_rdy", {AWREADY, WREADY}, 2'b00);
      chk("t4_regq", reg_q, pack());
    end
    if (bq.size() != 0) void'(bq.pop_front());
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk("t4_bdrop", BVALID, 1'b0);
    chk("t4_rdy1", {AWREADY, WREADY}, 2'b11);
    expect_write(32'h18, 32'h66666666, 4'h5);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check_b("t4b", 16'h0040);
    b_accept("t4b");

    write_same("t5pre", 32'hC, 32'h1, 4'hF, 16'h0008);
    ARADDR = 32'hC; ARVALID = 1'b1;
    AWADDR = 32'hC; WDATA = 32'h2; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    expect_read(32'hC);
    expect_write(32'hC, 32'h2, 4'hF);
    @(posedge ACLK); #1;
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check_r("t5");
    check_b("t5", 16'h0008);
    BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0; RREADY = 1'b0;
    @(negedge ACLK);
    chk("t5_drop", {BVALID, RVALID}, 2'b00);
    do_read("t5rd", 32'hC);

    AWADDR = 32'h10; AWVALID = 1'b1;
    ARADDR = 32'h0; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; ARVALID = 1'b0;
    @(negedge ACLK);
    chk("t6_rvalid", RVALID, 1'b1);
    chk("t6_awheld", AWREADY, 1'b0);
    ARESET = 1'b1;
    #1;
    chk("t6_rst_rdy", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(negedge ACLK);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    chk("t6_drop", {BVALID, RVALID}, 2'b00);
    chk("t6_regq", reg_q, pack());
    ARESET = 1'b0;
    @(negedge ACLK);
    WDATA = 32'h77777777; WSTRB = 4'hF; WVALID = 1'b1;
    chk("t6_wrdy", WREADY, 1'b1);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("t6_nob", BVALID, 1'b0);
      chk("t6_nopulse", reg_wr_pulse, 16'h0);
    end
    chk("t6_regq_end", reg_q, pack());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
